pc_gen: RTL and testbench

PC_GEN -- requirements
Module: pc_gen

---
 rtl/pc_gen.sv | 121 ++++++++++++
 tb/tb_pc_gen.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_gen.sv
// Fetch program-counter generator: picks sequential, branch or exception-vector
// next PC, latches synchronous exceptions, and tracks PC/valid per pipeline stage.
module pc_gen #(
    parameter int unsigned     AW         = 32,
    parameter logic [AW-1:0]   RESET_VEC  = '0,
    parameter logic [AW-1:0]   LOVEC_BASE = '0,
    parameter logic [AW-1:0]   HIVEC_BASE = AW'(32'hFFFF_0000),
    parameter int unsigned     DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  i_thumb,
    input  logic                  i_hivec,
    input  logic                  i_pc_en,
    input  logic [AW-1:0]         i_pc_reg,
    input  logic [5:0]            i_exc_req,
    input  logic                  i_irq_mask,
    input  logic                  i_fiq_mask,
    output logic [AW-1:0]         o_pc,
    output logic [AW-1:0]         o_pc_next,
    output logic [DEPTH*AW-1:0]   o_stage_pc,
    output logic [DEPTH-1:0]      o_stage_vld,
    output logic                  o_exc_taken,
    output logic [2:0]            o_exc_id,
    output logic [AW-1:0]         o_exc_ret
);

    logic [3:0]                 pend;
    logic [3:0]                 pend_clr;
    logic [5:0]                 eligible;
    logic                       exc_any;
    logic                       take;
    logic                       flush;
    logic [2:0]                 exc_id;
    logic [7:0]                 vec_off;
    logic [AW-1:0]              vec_base;
    logic [DEPTH-1:0][AW-1:0]   stage_pc;

    // irq/fiq are level-only; the four synchronous sources also count while still pending
    assign eligible = {i_exc_req[5] & ~i_fiq_mask,
                       i_exc_req[4] & ~i_irq_mask,
                       pend | i_exc_req[3:0]};
    assign exc_any  = |eligible;
    assign take     = en & exc_any;
    assign flush    = exc_any | i_pc_en;
    assign vec_base = i_hivec ? HIVEC_BASE : LOVEC_BASE;

    always_comb begin
        exc_id  = 3'd0;
        vec_off = 8'h00;
        if (eligible[3]) begin
            exc_id  = 3'd3;
            vec_off = 8'h10;
        end else if (eligible[5]) begin
            exc_id  = 3'd5;
            vec_off = 8'h1C;
        end else if (eligible[4]) begin
            exc_id  = 3'd4;
            vec_off = 8'h18;
        end else if (eligible[2]) begin
            exc_id  = 3'd2;
            vec_off = 8'h0C;
        end else if (eligible[0]) begin
            exc_id  = 3'd0;
            vec_off = 8'h04;
        end else if (eligible[1]) begin
            exc_id  = 3'd1;
            vec_off = 8'h08;
        end
    end

    always_comb begin
        pend_clr = 4'b0000;
        if (take && (exc_id < 3'd4)) begin
            pend_clr = 4'b0001 << exc_id[1:0];
        end
    end

    always_comb begin
        if (take) begin
            o_pc_next = vec_base + AW'(vec_off);
        end else if (i_pc_en) begin
            o_pc_next = i_pc_reg;
        end else begin
            o_pc_next = o_pc + (i_thumb ? AW'(2) : AW'(4));
        end
    end

    // Pending capture runs every edge; everything else advances only when enabled
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o_pc        <= RESET_VEC;
            pend        <= '0;
            stage_pc    <= '0;
            o_stage_vld <= '0;
            o_exc_taken <= 1'b0;
            o_exc_id    <= 3'd0;
            o_exc_ret   <= '0;
        end else begin
            pend        <= (pend | i_exc_req[3:0]) & ~pend_clr;
            o_exc_taken <= take;
            if (en) begin
                o_pc           <= o_pc_next;
                stage_pc[0]    <= o_pc;
                o_stage_vld[0] <= ~flush;
                for (int k = 1; k < int'(DEPTH); k++) begin
                    stage_pc[k]    <= stage_pc[k-1];
                    o_stage_vld[k] <= o_stage_vld[k-1] & ~flush;
                end
                if (take) begin
                    o_exc_id  <= exc_id;
                    o_exc_ret <= o_pc;
                end
            end
        end
    end

    assign o_stage_pc = stage_pc;

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed vector table, a reset-during-flush
// sequence, then randomized traffic against a behavioural model.
module tb_pc_gen;

    localparam int          AW    = 32;
    localparam int          DEPTH = 2;
    localparam logic [31:0] HIVEC = 32'hFFFF_0000;

    typedef struct packed {
        logic        rst_n;
        logic        en;
        logic        thumb;
        logic        hivec;
        logic        pc_en;
        logic [31:0] pc_reg;
        logic [5:0]  req;
        logic        imask;
        logic        fmask;
    } stim_t;

    typedef struct packed {
        stim_t       s;
        logic [31:0] pc;
        logic [1:0]  vld;
        logic        taken;
        logic [2:0]  id;
        logic [31:0] ret;
    } vec_t;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  en;
    logic                  i_thumb;
    logic                  i_hivec;
    logic                  i_pc_en;
    logic [AW-1:0]         i_pc_reg;
    logic [5:0]            i_exc_req;
    logic                  i_irq_mask;
    logic                  i_fiq_mask;
    logic [AW-1:0]         o_pc;
    logic [AW-1:0]         o_pc_next;
    logic [DEPTH*AW-1:0]   o_stage_pc;
    logic [DEPTH-1:0]      o_stage_vld;
    logic                  o_exc_taken;
    logic [2:0]            o_exc_id;
    logic [AW-1:0]         o_exc_ret;

    int n_vec  = 0;
    int n_miss = 0;

    // Behavioural model state: pipeline is a history of fetch PCs plus a refill count
    logic [31:0] m_pc;
    logic [3:0]  m_pend;
    logic [31:0] m_hist[$];
    int          m_fill;
    logic        m_taken;
    logic [2:0]  m_id;
    logic [31:0] m_ret;

    int          prio[6]    = '{3, 5, 4, 2, 0, 1};
    logic [31:0] vec_off[6] = '{32'h04, 32'h08, 32'h0C, 32'h10, 32'h18, 32'h1C};

    vec_t tbl[15];

    pc_gen #(.AW(AW), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .i_thumb     (i_thumb),
        .i_hivec     (i_hivec),
        .i_pc_en     (i_pc_en),
        .i_pc_reg    (i_pc_reg),
        .i_exc_req   (i_exc_req),
        .i_irq_mask  (i_irq_mask),
        .i_fiq_mask  (i_fiq_mask),
        .o_pc        (o_pc),
        .o_pc_next   (o_pc_next),
        .o_stage_pc  (o_stage_pc),
        .o_stage_vld (o_stage_vld),
        .o_exc_taken (o_exc_taken),
        .o_exc_id    (o_exc_id),
        .o_exc_ret   (o_exc_ret)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int model_pick();
        logic [5:0] src;
        src[3:0] = m_pend | i_exc_req[3:0];
        src[4]   = i_exc_req[4] && !i_irq_mask;
        src[5]   = i_exc_req[5] && !i_fiq_mask;
        for (int i = 0; i < 6; i++) begin
            if (src[prio[i]]) return prio[i];
        end
        return -1;
    endfunction

    function automatic logic [31:0] model_pc_next();
        int p;
        p = model_pick();
        if (en && p >= 0) return (i_hivec ? HIVEC : 32'h0) + vec_off[p];
        if (i_pc_en) return i_pc_reg;
        return m_pc + (i_thumb ? 32'd2 : 32'd4);
    endfunction

    task automatic model_step();
        int          p;
        logic [31:0] pre;
        logic [3:0]  pn;
        if (!rst_n) begin
            m_pc   = 32'h0;
            m_pend = 4'h0;
            m_hist.delete();
            for (int k = 0; k < DEPTH; k++) m_hist.push_back(32'h0);
            m_fill  = 0;
            m_taken = 1'b0;
            m_id    = 3'd0;
            m_ret   = 32'h0;
        end else begin
            p       = model_pick();
            pn      = m_pend | i_exc_req[3:0];
            m_taken = 1'b0;
            if (en) begin
                pre  = m_pc;
                m_pc = model_pc_next();
                m_hist.push_front(pre);
                void'(m_hist.pop_back());
                if (p >= 0 || i_pc_en) m_fill = 0;
                else if (m_fill < DEPTH) m_fill++;
                if (p >= 0) begin
                    m_taken = 1'b1;
                    m_id    = 3'(p);
                    m_ret   = pre;
                    if (p < 4) pn[p] = 1'b0;
                end
            end
            m_pend = pn;
        end
    endtask

    task automatic checkOutput(input string tag);
        logic [63:0]      sp;
        logic [DEPTH-1:0] v;
        sp = '0;
        for (int k = 0; k < DEPTH; k++) begin
            sp[k*32 +: 32] = m_hist[k];
            v[k]           = (k < m_fill);
        end
        check({tag, ".pc"},       64'(o_pc),        64'(m_pc));
        check({tag, ".vld"},      64'(o_stage_vld), 64'(v));
        check({tag, ".stage_pc"}, 64'(o_stage_pc),  sp);
        check({tag, ".taken"},    64'(o_exc_taken), 64'(m_taken));
        check({tag, ".id"},       64'(o_exc_id),    64'(m_id));
        check({tag, ".ret"},      64'(o_exc_ret),   64'(m_ret));
    endtask

    task automatic applyStimulus(input stim_t s, input string tag);
        rst_n      = s.rst_n;
        en         = s.en;
        i_thumb    = s.thumb;
        i_hivec    = s.hivec;
        i_pc_en    = s.pc_en;
        i_pc_reg   = s.pc_reg;
        i_exc_req  = s.req;
        i_irq_mask = s.imask;
        i_fiq_mask = s.fmask;
        #1;
        check({tag, ".pc_next"}, 64'(o_pc_next), 64'(model_pc_next()));
        @(posedge clk);
        model_step();
        #1;
        checkOutput(tag);
    endtask

    function automatic vec_t mk(input logic rn, input logic e, input logic th, input logic hv,
                                input logic pe, input logic [31:0] pr, input logic [5:0] rq,
                                input logic im, input logic fm, input logic [31:0] pc,
                                input logic [1:0] vld, input logic tk, input logic [2:0] id,
                                input logic [31:0] ret);
        vec_t v;
        v.s.rst_n  = rn;
        v.s.en     = e;
        v.s.thumb  = th;
        v.s.hivec  = hv;
        v.s.pc_en  = pe;
        v.s.pc_reg = pr;
        v.s.req    = rq;
        v.s.imask  = im;
        v.s.fmask  = fm;
        v.pc       = pc;
        v.vld      = vld;
        v.taken    = tk;
        v.id       = id;
        v.ret      = ret;
        return v;
    endfunction

    task automatic checkDirected(input string tag, input logic [31:0] pc, input logic [1:0] vld,
                                 input logic tk, input logic [2:0] id, input logic [31:0] ret);
        check({tag, ".exp_pc"},    64'(o_pc),        64'(pc));
        check({tag, ".exp_vld"},   64'(o_stage_vld), 64'(vld));
        check({tag, ".exp_taken"}, 64'(o_exc_taken), 64'(tk));
        check({tag, ".exp_id"},    64'(o_exc_id),    64'(id));
        check({tag, ".exp_ret"},   64'(o_exc_ret),   64'(ret));
    endtask

    initial begin
        stim_t s;
        logic [31:0] r;

        //            rn e th hv pe pc_reg        req        im fm  pc            vld   tk id ret
        tbl[0]  = mk(0, 1, 0, 0, 0, 32'h0,        6'b000000, 0, 0, 32'h0,        2'b00, 0, 0, 32'h0);
        tbl[1]  = mk(1, 1, 0, 0, 0, 32'h0,        6'b000000, 0, 0, 32'h4,        2'b01, 0, 0, 32'h0);
        tbl[2]  = mk(1, 1, 0, 0, 0, 32'h0,        6'b000000, 0, 0, 32'h8,        2'b11, 0, 0, 32'h0);
        tbl[3]  = mk(1, 1, 0, 0, 0, 32'h0,        6'b000000, 0, 0, 32'hC,        2'b11, 0, 0, 32'h0);
        tbl[4]  = mk(1, 1, 0, 1, 1, 32'h100,      6'b010000, 0, 0, 32'hFFFF0018, 2'b00, 1, 4, 32'hC);
        tbl[5]  = mk(1, 1, 0, 1, 0, 32'h0,        6'b000000, 0, 0, 32'hFFFF001C, 2'b01, 0, 4, 32'hC);
        tbl[6]  = mk(1, 0, 0, 1, 0, 32'h0,        6'b000010, 0, 0, 32'hFFFF001C, 2'b01, 0, 4, 32'hC);
        tbl[7]  = mk(1, 0, 0, 1, 0, 32'h0,        6'b000000, 0, 0, 32'hFFFF001C, 2'b01, 0, 4, 32'hC);
        tbl[8]  = mk(1, 1, 0, 0, 0, 32'h0,        6'b000000, 0, 0, 32'h8,        2'b00, 1, 1, 32'hFFFF001C);
        tbl[9]  = mk(1, 1, 0, 0, 0, 32'h0,        6'b000000, 0, 0, 32'hC,        2'b01, 0, 1, 32'hFFFF001C);
        tbl[10] = mk(1, 1, 0, 0, 0, 32'h0,        6'b101000, 0, 0, 32'h10,       2'b00, 1, 3, 32'hC);
        tbl[11] = mk(1, 1, 0, 0, 0, 32'h0,        6'b100000, 0, 0, 32'h1C,       2'b00, 1, 5, 32'h10);
        tbl[12] = mk(1, 1, 0, 0, 0, 32'h0,        6'b100000, 0, 1, 32'h20,       2'b01, 0, 5, 32'h10);
        tbl[13] = mk(1, 1, 0, 0, 1, 32'hFFFFFFFE, 6'b000000, 0, 0, 32'hFFFFFFFE, 2'b00, 0, 5, 32'h10);
        tbl[14] = mk(1, 1, 1, 0, 0, 32'h0,        6'b000000, 0, 0, 32'h0,        2'b01, 0, 5, 32'h10);

        rst_n      = 1'b0;
        en         = 1'b0;
        i_thumb    = 1'b0;
        i_hivec    = 1'b0;
        i_pc_en    = 1'b0;
        i_pc_reg   = '0;
        i_exc_req  = '0;
        i_irq_mask = 1'b0;
        i_fiq_mask = 1'b0;
        @(posedge clk);
        model_step();
        #1;

        for (int i = 0; i < 15; i++) begin
            applyStimulus(tbl[i].s, $sformatf("row%0d", i));
            checkDirected($sformatf("row%0d", i), tbl[i].pc, tbl[i].vld,
                          tbl[i].taken, tbl[i].id, tbl[i].ret);
        end

        // Pending undef is wiped by a reset that lands on a redirect edge
        s = mk(1, 0, 0, 0, 0, 32'h0, 6'b000001, 0, 0, 0, 0, 0, 0, 0).s;
        applyStimulus(s, "rst1");
        checkDirected("rst1", 32'h0, 2'b01, 1'b0, 3'd5, 32'h10);
        s = mk(0, 1, 0, 0, 1, 32'h200, 6'b000000, 0, 0, 0, 0, 0, 0, 0).s;
        applyStimulus(s, "rst2");
        checkDirected("rst2", 32'h0, 2'b00, 1'b0, 3'd0, 32'h0);
        s = mk(1, 1, 0, 1, 0, 32'h0, 6'b000000, 0, 0, 0, 0, 0, 0, 0).s;
        applyStimulus(s, "rst3");
        checkDirected("rst3", 32'h4, 2'b01, 1'b0, 3'd0, 32'h0);
        s = mk(1, 0, 0, 0, 1, 32'h300, 6'b000000, 0, 0, 0, 0, 0, 0, 0).s;
        applyStimulus(s, "stall");
        checkDirected("stall", 32'h4, 2'b01, 1'b0, 3'd0, 32'h0);
        s = mk(1, 1, 0, 0, 0, 32'h0, 6'b000000, 0, 0, 0, 0, 0, 0, 0).s;
        applyStimulus(s, "resume");
        checkDirected("resume", 32'h8, 2'b11, 1'b0, 3'd0, 32'h0);

        for (int n = 0; n < 3000; n++) begin
            s.rst_n = ($urandom_range(0, 99) >= 2);
            s.en    = ($urandom_range(0, 99) < 75);
            s.thumb = ($urandom_range(0, 1) == 1);
            s.hivec = ($urandom_range(0, 1) == 1);
            s.pc_en = ($urandom_range(0, 99) < 20);
            r = $urandom();
            s.pc_reg = ($urandom_range(0, 9) == 0) ? (32'hFFFF_FFF0 | (r & 32'hE)) : (r & 32'hFFFF_FFFE);
            for (int b = 0; b < 6; b++) s.req[b] = ($urandom_range(0, 99) < 10);
            s.imask = ($urandom_range(0, 3) == 0);
            s.fmask = ($urandom_range(0, 3) == 0);
            applyStimulus(s, $sformatf("rnd%0d", n));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
